// File: rtl/btn_ctrl_pkg.sv
// Shared types and constants for the on-screen button menu controller.
package btn_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PRESS   = 2'd1,
      HOLD    = 2'd2,
      RELEASE = 2'd3
   } menu_state_t;

   // Front-face travel equals the drawn shadow inset, in pixels.
   localparam logic [2:0] MAX_OFFSET = 3'd4;

endpackage

// File: rtl/button_menu_ctrl_if.sv
// Bundle of frame tick, raw push-buttons and menu outputs shared by the
// controller (slave) and whatever drives it (master).
interface button_menu_ctrl_if #(
   parameter int N_BTN = 4
);
   import btn_ctrl_pkg::*;

   localparam int SEL_W = $clog2(N_BTN);

   // No valid/ready here: frame_tick and select_pulse are single-cycle strobes
   // with no back-pressure; raw buttons are asynchronous levels; all outputs
   // are registered and change only on the rising edge of clk.
   logic             frame_tick;
   logic             btn_left_raw;
   logic             btn_right_raw;
   logic             btn_sel_raw;
   logic [SEL_W-1:0] sel_idx;
   logic [2:0]       press_offset;
   logic             pressing;
   logic             select_pulse;
   logic [SEL_W-1:0] select_idx;
   menu_state_t      state;

   modport master (
      output frame_tick, btn_left_raw, btn_right_raw, btn_sel_raw,
      input  sel_idx, press_offset, pressing, select_pulse, select_idx, state
   );

   modport slave (
      input  frame_tick, btn_left_raw, btn_right_raw, btn_sel_raw,
      output sel_idx, press_offset, pressing, select_pulse, select_idx, state
   );

endinterface

// File: rtl/btn_debounce.sv
// Per-button conditioning: 2-flop synchronizer, optional stability filter
// (BTN_DEBOUNCE_EN) and a one-cycle rising-edge event.
module btn_debounce #(
   parameter int DEB_CYCLES = 500000
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic rise
);

   if (DEB_CYCLES < 1) begin : g_param_check
      $error("btn_debounce: DEB_CYCLES must be at least 1");
   end

   logic [1:0] sync;
   logic [1:0] valid;
   logic       armed;
   logic       level;
   logic       level_d;

   // armed stays low until the synchronized input has really been seen low,
   // so a button held across reset cannot produce an event.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync    <= 2'b00;
         valid   <= 2'b00;
         armed   <= 1'b0;
         level_d <= 1'b0;
      end else begin
         sync    <= {sync[0], raw};
         valid   <= {valid[0], 1'b1};
         armed   <= armed | (valid[1] & ~sync[1]);
         level_d <= level;
      end
   end

`ifdef BTN_DEBOUNCE_EN
   localparam int CNT_W = $clog2(DEB_CYCLES + 1);
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         level <= 1'b0;
         cnt   <= '0;
      end else if (sync[1] == level) begin
         cnt <= '0;
      end else if (cnt == CNT_W'(DEB_CYCLES - 1)) begin
         level <= sync[1];
         cnt   <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end
`else
   assign level = sync[1];
`endif

   assign rise = level & ~level_d & armed;

endmodule

// File: rtl/button_menu_ctrl.sv
// Button menu controller: left/right move the highlight, select plays a
// press/hold/release animation and confirms. Optional: BTN_DEBOUNCE_EN.
module button_menu_ctrl
   import btn_ctrl_pkg::*;
#(
   parameter int N_BTN       = 4,
   parameter int DEB_CYCLES  = 500000,
   parameter int HOLD_FRAMES = 8
) (
   input logic              clk,
   input logic              rst,
   button_menu_ctrl_if.slave bus
);

   localparam int SEL_W = $clog2(N_BTN);
   localparam int FC_W  = $clog2(HOLD_FRAMES + 1);

   if (N_BTN < 2 || N_BTN > 16 || HOLD_FRAMES < 1) begin : g_param_check
      $error("button_menu_ctrl: parameter out of range");
   end

   logic left_ev, right_ev, sel_ev;

   btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_left (
      .clk(clk), .rst(rst), .raw(bus.btn_left_raw), .rise(left_ev));
   btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_right (
      .clk(clk), .rst(rst), .raw(bus.btn_right_raw), .rise(right_ev));
   btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_sel (
      .clk(clk), .rst(rst), .raw(bus.btn_sel_raw), .rise(sel_ev));

   menu_state_t      state, state_n;
   logic [SEL_W-1:0] sel_q, sel_n, seli_q, seli_n;
   logic [2:0]       off_q, off_n;
   logic [FC_W-1:0]  fcnt_q, fcnt_n;
   logic             pulse_q, pulse_n;
   logic             pressing_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         sel_q      <= '0;
         seli_q     <= '0;
         off_q      <= '0;
         fcnt_q     <= '0;
         pulse_q    <= 1'b0;
         pressing_q <= 1'b0;
      end else begin
         state      <= state_n;
         sel_q      <= sel_n;
         seli_q     <= seli_n;
         off_q      <= off_n;
         fcnt_q     <= fcnt_n;
         pulse_q    <= pulse_n;
         pressing_q <= (state_n != IDLE);
      end
   end

   // Events are consumed only in IDLE; elsewhere they fall on the floor.
   always_comb begin
      state_n = state;
      sel_n   = sel_q;
      seli_n  = seli_q;
      off_n   = off_q;
      fcnt_n  = fcnt_q;
      pulse_n = 1'b0;
      case (state)
         IDLE: begin
            if (sel_ev) begin
               seli_n  = sel_q;
               state_n = PRESS;
            end else if (left_ev && !right_ev) begin
               sel_n = (sel_q == '0) ? SEL_W'(N_BTN - 1) : sel_q - 1'b1;
            end else if (right_ev && !left_ev) begin
               sel_n = (sel_q == SEL_W'(N_BTN - 1)) ? '0 : sel_q + 1'b1;
            end
         end
         PRESS: begin
            if (bus.frame_tick) begin
               if (off_q >= MAX_OFFSET - 3'd1) begin
                  off_n   = MAX_OFFSET;
                  fcnt_n  = '0;
                  state_n = HOLD;
               end else begin
                  off_n = off_q + 3'd1;
               end
            end
         end
         HOLD: begin
            if (bus.frame_tick) begin
               if (fcnt_q == FC_W'(HOLD_FRAMES - 1)) begin
                  fcnt_n  = '0;
                  pulse_n = 1'b1;
                  state_n = RELEASE;
               end else begin
                  fcnt_n = fcnt_q + 1'b1;
               end
            end
         end
         RELEASE: begin
            if (bus.frame_tick) begin
               if (off_q <= 3'd1) begin
                  off_n   = '0;
                  state_n = IDLE;
               end else begin
                  off_n = off_q - 3'd1;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   assign bus.sel_idx      = sel_q;
   assign bus.select_idx   = seli_q;
   assign bus.press_offset = off_q;
   assign bus.pressing     = pressing_q;
   assign bus.select_pulse = pulse_q;
   assign bus.state        = state;

endmodule

// File: tb/tb_button_menu_ctrl.sv
// Directed bench for button_menu_ctrl (N_BTN=4, DEB_CYCLES=4, HOLD_FRAMES=8,
// frame_tick every 20 cycles). Build with or without BTN_DEBOUNCE_EN.
module tb_button_menu_ctrl;
   import btn_ctrl_pkg::*;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   button_menu_ctrl_if #(.N_BTN(4)) bus ();

   button_menu_ctrl #(
      .N_BTN(4), .DEB_CYCLES(4), .HOLD_FRAMES(8)
   ) dut (
      .clk(clk), .rst(rst), .bus(bus)
   );

   // clock / frame tick
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      bus.frame_tick = 1'b0;
      forever begin
         repeat (19) @(negedge clk) bus.frame_tick = 1'b0;
         @(negedge clk) bus.frame_tick = 1'b1;
      end
   end

   // driver tasks
   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic drive_btns(input logic l, input logic r, input logic s, input int hi);
      @(negedge clk);
      bus.btn_left_raw  = l;
      bus.btn_right_raw = r;
      bus.btn_sel_raw   = s;
      repeat (hi) @(negedge clk);
      bus.btn_left_raw  = 1'b0;
      bus.btn_right_raw = 1'b0;
      bus.btn_sel_raw   = 1'b0;
   endtask

   task automatic wait_tick();
      int n = 0;
      do begin
         @(posedge clk);
         n++;
      end while (!bus.frame_tick && n < 60);
      @(negedge clk);
      checks++;
      if (n >= 60) begin
         errors++;
         $display("FAIL tick_timeout: waited %0d cycles, required < 60", n);
      end
   endtask

   task automatic wait_state(input menu_state_t target, input int budget);
      int n = 0;
      while (bus.state !== target && n < budget) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (bus.state !== target) begin
         errors++;
         $display("FAIL wait_state: got %s, required %s within %0d cycles",
                  bus.state.name(), target.name(), budget);
      end
   endtask

   task automatic check_sel(input string tag, input logic [1:0] exp);
      checks++;
      if (bus.sel_idx !== exp) begin
         errors++;
         $display("FAIL %s: sel_idx=%0d required %0d", tag, bus.sel_idx, exp);
      end
   endtask

   // scenarios
   task automatic test_reset();
      rst = 1'b1;
      bus.btn_left_raw = 1'b0; bus.btn_right_raw = 1'b0; bus.btn_sel_raw = 1'b0;
      idle(3);
      checks++;
      if (bus.state !== IDLE || bus.sel_idx !== 2'd0 || bus.select_idx !== 2'd0 ||
          bus.press_offset !== 3'd0 || bus.pressing !== 1'b0 || bus.select_pulse !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: state=%s sel=%0d seli=%0d off=%0d pr=%b sp=%b required IDLE 0 0 0 0 0",
                  bus.state.name(), bus.sel_idx, bus.select_idx, bus.press_offset,
                  bus.pressing, bus.select_pulse);
      end
      rst = 1'b0;
      idle(5);
   endtask

   task automatic test_navigation();
      logic [1:0] exp_r [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
      for (int i = 0; i < 4; i++) begin
         drive_btns(1'b0, 1'b1, 1'b0, 10);
         idle(10);
         check_sel("nav_right", exp_r[i]);
      end
      drive_btns(1'b1, 1'b0, 1'b0, 10);
      idle(10);
      check_sel("nav_left_wrap", 2'd3);
      drive_btns(1'b1, 1'b0, 1'b0, 10);
      idle(10);
      check_sel("nav_left", 2'd2);
   endtask

   task automatic test_press_cycle();
      logic [2:0] exp_up [4] = '{3'd1, 3'd2, 3'd3, 3'd4};
      logic [2:0] exp_dn [4] = '{3'd3, 3'd2, 3'd1, 3'd0};
      wait_tick();
      drive_btns(1'b0, 1'b0, 1'b1, 10);
      checks++;
      if (bus.state !== PRESS || bus.press_offset !== 3'd0 || bus.pressing !== 1'b1) begin
         errors++;
         $display("FAIL press_start: state=%s off=%0d pr=%b required PRESS 0 1",
                  bus.state.name(), bus.press_offset, bus.pressing);
      end
      for (int i = 0; i < 4; i++) begin
         wait_tick();
         checks++;
         if (bus.press_offset !== exp_up[i]) begin
            errors++;
            $display("FAIL press_up: offset=%0d required %0d", bus.press_offset, exp_up[i]);
         end
      end
      checks++;
      if (bus.state !== HOLD) begin
         errors++;
         $display("FAIL hold_entry: state=%s required HOLD", bus.state.name());
      end
      for (int i = 1; i <= 7; i++) begin
         wait_tick();
         checks++;
         if (bus.select_pulse !== 1'b0 || bus.state !== HOLD) begin
            errors++;
            $display("FAIL hold_tick%0d: pulse=%b state=%s required 0 HOLD",
                     i, bus.select_pulse, bus.state.name());
         end
      end
      wait_tick();
      checks++;
      if (bus.select_pulse !== 1'b1 || bus.select_idx !== 2'd2 || bus.state !== RELEASE ||
          bus.press_offset !== 3'd4) begin
         errors++;
         $display("FAIL select_pulse: pulse=%b seli=%0d state=%s off=%0d required 1 2 RELEASE 4",
                  bus.select_pulse, bus.select_idx, bus.state.name(), bus.press_offset);
      end
      idle(1);
      checks++;
      if (bus.select_pulse !== 1'b0) begin
         errors++;
         $display("FAIL pulse_width: pulse=%b required 0", bus.select_pulse);
      end
      for (int i = 0; i < 4; i++) begin
         wait_tick();
         checks++;
         if (bus.press_offset !== exp_dn[i]) begin
            errors++;
            $display("FAIL release_down: offset=%0d required %0d", bus.press_offset, exp_dn[i]);
         end
      end
      checks++;
      if (bus.state !== IDLE || bus.pressing !== 1'b0) begin
         errors++;
         $display("FAIL back_idle: state=%s pr=%b required IDLE 0", bus.state.name(), bus.pressing);
      end
   endtask

   task automatic test_glitch();
      wait_tick();
      drive_btns(1'b0, 1'b0, 1'b1, 2);
      idle(12);
`ifdef BTN_DEBOUNCE_EN
      checks++;
      if (bus.state !== IDLE) begin
         errors++;
         $display("FAIL glitch_filtered: state=%s required IDLE", bus.state.name());
      end
`else
      checks++;
      if (bus.state !== PRESS) begin
         errors++;
         $display("FAIL glitch_passes: state=%s required PRESS", bus.state.name());
      end
      wait_state(IDLE, 600);
`endif
      check_sel("glitch_sel", 2'd2);
   endtask

   task automatic test_simultaneous();
      drive_btns(1'b1, 1'b1, 1'b0, 10);
      idle(10);
      check_sel("left_right_same", 2'd2);
      wait_tick();
      drive_btns(1'b0, 1'b1, 1'b1, 10);
      checks++;
      if (bus.state !== PRESS || bus.sel_idx !== 2'd2 || bus.select_idx !== 2'd2) begin
         errors++;
         $display("FAIL sel_beats_move: state=%s sel=%0d seli=%0d required PRESS 2 2",
                  bus.state.name(), bus.sel_idx, bus.select_idx);
      end
      wait_state(IDLE, 600);
      check_sel("sel_move_after", 2'd2);
   endtask

   task automatic test_move_in_release();
      wait_tick();
      drive_btns(1'b0, 1'b0, 1'b1, 10);
      wait_state(RELEASE, 400);
      drive_btns(1'b0, 1'b1, 1'b0, 10);
      idle(10);
      wait_state(IDLE, 200);
      idle(10);
      check_sel("move_in_release", 2'd2);
   endtask

   task automatic test_reset_in_hold();
      int pulses = 0;
      wait_tick();
      drive_btns(1'b0, 1'b0, 1'b1, 10);
      repeat (6) wait_tick();
      checks++;
      if (bus.state !== HOLD || bus.press_offset !== 3'd4) begin
         errors++;
         $display("FAIL pre_reset_hold: state=%s off=%0d required HOLD 4",
                  bus.state.name(), bus.press_offset);
      end
      rst = 1'b1;
      idle(1);
      checks++;
      if (bus.state !== IDLE || bus.press_offset !== 3'd0 || bus.pressing !== 1'b0 ||
          bus.select_pulse !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_anim: state=%s off=%0d pr=%b sp=%b required IDLE 0 0 0",
                  bus.state.name(), bus.press_offset, bus.pressing, bus.select_pulse);
      end
      rst = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (bus.select_pulse === 1'b1) pulses++;
      end
      checks++;
      if (pulses != 0) begin
         errors++;
         $display("FAIL no_pulse_after_reset: saw %0d pulses required 0", pulses);
      end
      check_sel("sel_after_reset", 2'd0);
   endtask

   task automatic test_held_through_reset();
      @(negedge clk);
      rst = 1'b1;
      bus.btn_right_raw = 1'b1;
      idle(3);
      rst = 1'b0;
      idle(20);
      check_sel("held_no_event", 2'd0);
      bus.btn_right_raw = 1'b0;
      idle(10);
      check_sel("held_release", 2'd0);
      drive_btns(1'b0, 1'b1, 1'b0, 10);
      idle(10);
      check_sel("held_repress", 2'd1);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b1;
      bus.btn_left_raw = 1'b0; bus.btn_right_raw = 1'b0; bus.btn_sel_raw = 1'b0;
      test_reset();
      test_navigation();
      test_press_cycle();
      test_glitch();
      test_simultaneous();
      test_move_in_release();
      test_reset_in_hold();
      test_held_through_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule
